// File: rtl/proj_qsys_nios_oci_dct_packer_pkg.sv
// Shared constants for the OCI data-capture trace packer: frame geometry and FSM encoding.
package proj_qsys_nios_oci_dct_packer_pkg;

  localparam int FRAME_W = 2;
  localparam int FRAMES  = 15;
  localparam int CNT_W   = 4;
  localparam int BUF_W   = FRAME_W * FRAMES;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAMES);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ENDED = 2'd2;

  // Places one frame into the slot selected by idx; other slots are left untouched.
  function automatic logic [BUF_W-1:0] insert_frame(
    input logic [BUF_W-1:0]   acc,
    input logic [CNT_W-1:0]   idx,
    input logic [FRAME_W-1:0] data
  );
    logic [BUF_W-1:0] r;
    r = acc;
    for (int i = 0; i < FRAMES; i++) begin
      if (idx == CNT_W'(i)) r[FRAME_W*i +: FRAME_W] = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/proj_qsys_nios_oci_dct_outreg.sv
// Single-entry valid/ready holding register; a load may coincide with the consume of the old word.
module proj_qsys_nios_oci_dct_outreg
  import proj_qsys_nios_oci_dct_packer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buffer,
  input  logic [CNT_W-1:0] load_count,
  input  logic             ready,
  output logic             valid,
  output logic [BUF_W-1:0] buffer,
  output logic [CNT_W-1:0] count,
  output logic             free
);

  assign free = ~valid | ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      buffer <= '0;
      count  <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      buffer <= load_buffer;
      count  <= load_count;
    end else if (ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/proj_qsys_nios_oci_dct_packer.sv
// Packs 2-bit trace frames LSB-first into 30-bit words and sequences end-of-test draining.
// state    | meaning
// ST_RUN   | accepting frames, packing and emitting words
// ST_DRAIN | frames ignored, partial word flushed, waiting for output to empty
// ST_ENDED | drained; test_has_ended held until reset
module proj_qsys_nios_oci_dct_packer
  import proj_qsys_nios_oci_dct_packer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trace_en,
  input  logic                 frame_valid,
  input  logic [FRAME_W-1:0]   frame_data,
  input  logic                 flush,
  input  logic                 test_end_req,
  output logic                 dct_valid,
  input  logic                 dct_ready,
  output logic [BUF_W-1:0]     dct_buffer,
  output logic [CNT_W-1:0]     dct_count,
  output logic                 overflow,
  output logic                 test_ending,
  output logic                 test_has_ended
);

  logic [1:0]       state;
  logic [BUF_W-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;
  logic             flush_pend;

  logic             run;
  logic             offered;
  logic             accept;
  logic             drop;
  logic [BUF_W-1:0] acc_next;
  logic [CNT_W-1:0] acc_cnt_next;
  logic             flush_req;
  logic             out_free;
  logic             transfer;
  logic             drain_done;

  assign run          = (state == ST_RUN);
  assign offered      = frame_valid & trace_en & run;
  assign accept       = offered & (acc_cnt != CNT_FULL);
  assign drop         = offered & (acc_cnt == CNT_FULL);
  assign acc_next     = accept ? insert_frame(acc, acc_cnt, frame_data) : acc;
  assign acc_cnt_next = acc_cnt + CNT_W'(accept);

  // The end request itself starts the flush so the last partial word leaves without an extra cycle.
  assign flush_req  = flush | flush_pend | (state == ST_DRAIN) | (run & test_end_req);
  assign transfer   = out_free & ((acc_cnt_next == CNT_FULL) |
                                  (flush_req & (acc_cnt_next != '0)));
  assign drain_done = (state == ST_DRAIN) & (acc_cnt == '0) & out_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (transfer) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else begin
        acc     <= acc_next;
        acc_cnt <= acc_cnt_next;
      end

      if (transfer)                              flush_pend <= 1'b0;
      else if (flush && (acc_cnt_next != '0))    flush_pend <= 1'b1;

      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (test_end_req) state <= ST_DRAIN;
        ST_DRAIN: if (drain_done)   state <= ST_ENDED;
        ST_ENDED: state <= ST_ENDED;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign test_ending    = (state == ST_DRAIN);
  assign test_has_ended = (state == ST_ENDED);

  proj_qsys_nios_oci_dct_outreg u_outreg (
    .clk         (clk),
    .reset       (reset),
    .load        (transfer),
    .load_buffer (acc_next),
    .load_count  (acc_cnt_next),
    .ready       (dct_ready),
    .valid       (dct_valid),
    .buffer      (dct_buffer),
    .count       (dct_count),
    .free        (out_free)
  );

endmodule

// File: tb/tb_proj_qsys_nios_oci_dct_packer.sv
// Scenario bench for the trace packer, checked against a queue-based transaction model.
module tb_proj_qsys_nios_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en;
  logic        frame_valid;
  logic [1:0]  frame_data;
  logic        flush;
  logic        test_end_req;
  logic        dct_valid;
  logic        dct_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        test_ending;
  logic        test_has_ended;

  int checks   = 0;
  int failures = 0;

  // model: frames waiting to be packed, word in the output register, flags
  int m_acc[$];
  int m_out[$];
  bit m_valid;
  bit m_pend;
  bit m_ovf;
  int m_state;   // 0 running, 1 draining, 2 ended

  always #5 clk = ~clk;

  proj_qsys_nios_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .trace_en       (trace_en),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .flush          (flush),
    .test_end_req   (test_end_req),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .overflow       (overflow),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  function automatic logic [29:0] pack(input int q[$]);
    logic [29:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) w[2*i +: 2] = q[i][1:0];
    return w;
  endfunction

  task automatic step(input bit fv, input bit [1:0] fd, input bit fl, input bit te,
                      input bit rdy, input bit ten);
    bit offered, out_free, want, done;
    int pre_size;
    frame_valid = fv; frame_data = fd; flush = fl; test_end_req = te;
    dct_ready = rdy; trace_en = ten;
    pre_size = m_acc.size();
    offered  = fv && ten && (m_state == 0);
    if (offered) begin
      if (m_acc.size() < 15) m_acc.push_back(int'(fd));
      else m_ovf = 1'b1;
    end
    out_free = !m_valid || rdy;
    done     = (m_state == 1) && (pre_size == 0) && out_free;
    want     = (m_acc.size() == 15) ||
               ((fl || m_pend || m_state == 1 || (m_state == 0 && te)) && m_acc.size() > 0);
    if (m_valid && rdy) m_valid = 1'b0;
    if (want && out_free) begin
      m_out = m_acc;
      m_acc.delete();
      m_valid = 1'b1;
      m_pend  = 1'b0;
    end else if (fl && m_acc.size() > 0) begin
      m_pend = 1'b1;
    end
    if (m_state == 0 && te) m_state = 1;
    else if (done)          m_state = 2;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; frame_valid = 1'b0; frame_data = 2'd0; flush = 1'b0;
    test_end_req = 1'b0; dct_ready = 1'b1; trace_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_acc.delete(); m_out.delete();
    m_valid = 0; m_pend = 0; m_ovf = 0; m_state = 0;
  endtask

  task automatic test_reset();
    checks++; if (dct_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dct_valid); end
    checks++; if (dct_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dct_count); end
    checks++; if (dct_buffer !== 30'd0) begin failures++; $display("FAIL reset_buffer got=%h exp=0", dct_buffer); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (test_ending !== 1'b0) begin failures++; $display("FAIL reset_test_ending got=%b exp=0", test_ending); end
    checks++; if (test_has_ended !== 1'b0) begin failures++; $display("FAIL reset_test_has_ended got=%b exp=0", test_has_ended); end
  endtask

  task automatic test_full_word();
    int exp_q[$];
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(i % 4);
      step(1, 2'(i % 4), 0, 0, 1, 1);
    end
    checks++; if (dct_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", dct_valid); end
    checks++; if (dct_count !== 4'd15) begin failures++; $display("FAIL full_count got=%0d exp=15", dct_count); end
    checks++; if (dct_buffer !== pack(exp_q)) begin failures++; $display("FAIL full_buffer got=%h exp=%h", dct_buffer, pack(exp_q)); end
    step(0, 0, 0, 0, 1, 1);
    checks++; if (dct_valid !== 1'b0) begin failures++; $display("FAIL full_one_cycle got=%b exp=0", dct_valid); end
  endtask

  task automatic test_flush();
    step(1, 2'd3, 0, 0, 1, 1);
    step(1, 2'd2, 0, 0, 1, 1);
    step(1, 2'd1, 0, 0, 1, 1);
    step(1, 2'd0, 0, 0, 1, 1);
    checks++; if (dct_valid !== 1'b0) begin failures++; $display("FAIL flush_early_valid got=%b exp=0", dct_valid); end
    step(0, 0, 1, 0, 1, 1);
    checks++; if (dct_valid !== 1'b1) begin failures++; $display("FAIL flush_valid got=%b exp=1", dct_valid); end
    checks++; if (dct_count !== 4'd4) begin failures++; $display("FAIL flush_count got=%0d exp=4", dct_count); end
    checks++; if (dct_buffer !== 30'h01B) begin failures++; $display("FAIL flush_buffer got=%h exp=01b", dct_buffer); end
    step(0, 0, 1, 0, 1, 1);
    checks++; if (dct_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_noop got=%b exp=0", dct_valid); end
  endtask

  task automatic test_flush_same_cycle();
    step(1, 2'd1, 0, 0, 1, 1);
    step(1, 2'd2, 0, 0, 1, 1);
    step(1, 2'd3, 1, 0, 1, 1);
    checks++; if (dct_count !== 4'd3) begin failures++; $display("FAIL flush_same_count got=%0d exp=3", dct_count); end
    checks++; if (dct_buffer !== 30'h039) begin failures++; $display("FAIL flush_same_buffer got=%h exp=039", dct_buffer); end
    step(0, 0, 0, 0, 1, 1);
  endtask

  task automatic test_backpressure();
    int w1[$];
    int w2[$];
    int f;
    for (int i = 0; i < 31; i++) begin
      f = int'($urandom_range(0, 3));
      if (i < 15) w1.push_back(f);
      else if (i < 30) w2.push_back(f);
      step(1, 2'(f), 0, 0, 0, 1);
      if (i >= 14) begin
        checks++; if (dct_valid !== 1'b1 || dct_buffer !== pack(w1) || dct_count !== 4'd15) begin
          failures++; $display("FAIL hold_word cycle=%0d got=%b/%h/%0d exp=1/%h/15", i, dct_valid, dct_buffer, dct_count, pack(w1));
        end
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
    step(0, 0, 0, 0, 1, 1);
    checks++; if (dct_valid !== 1'b1 || dct_buffer !== pack(w2) || dct_count !== 4'd15) begin
      failures++; $display("FAIL bp_second_word got=%b/%h/%0d exp=1/%h/15", dct_valid, dct_buffer, dct_count, pack(w2));
    end
    step(0, 0, 0, 0, 1, 1);
    checks++; if (dct_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", dct_valid); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_drain();
    int q[$];
    int f;
    for (int i = 0; i < 7; i++) begin
      f = int'($urandom_range(0, 3));
      q.push_back(f);
      step(1, 2'(f), 0, 0, 1, 1);
    end
    step(0, 0, 0, 1, 0, 1);
    checks++; if (test_ending !== 1'b1) begin failures++; $display("FAIL drain_ending got=%b exp=1", test_ending); end
    checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd7 || dct_buffer !== pack(q)) begin
      failures++; $display("FAIL drain_word got=%b/%0d/%h exp=1/7/%h", dct_valid, dct_count, dct_buffer, pack(q));
    end
    for (int i = 0; i < 3; i++) step(1, 2'(i), 0, 0, 0, 1);
    checks++; if (dct_count !== 4'd7 || overflow !== 1'b0 || test_ending !== 1'b1) begin
      failures++; $display("FAIL drain_ignore got=%0d/%b/%b exp=7/0/1", dct_count, overflow, test_ending);
    end
    step(0, 0, 0, 0, 1, 1);
    checks++; if (test_ending !== 1'b0 || test_has_ended !== 1'b1 || dct_valid !== 1'b0) begin
      failures++; $display("FAIL drain_ended got=%b/%b/%b exp=0/1/0", test_ending, test_has_ended, dct_valid);
    end
    for (int i = 0; i < 5; i++) step(1, 2'd3, 1, 1, 1, 1);
    checks++; if (test_has_ended !== 1'b1 || dct_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL ended_sticky got=%b/%b/%b exp=1/0/0", test_has_ended, dct_valid, overflow);
    end
  endtask

  task automatic test_reset_midword();
    int q[$];
    int f;
    for (int i = 0; i < 8; i++) step(1, 2'd3, 0, 0, 1, 1);
    apply_reset();
    checks++; if (dct_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", dct_valid); end
    for (int i = 0; i < 15; i++) begin
      f = int'($urandom_range(0, 2));
      q.push_back(f);
      step(1, 2'(f), 0, 0, 1, 1);
    end
    checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== pack(q)) begin
      failures++; $display("FAIL midreset_word got=%b/%0d/%h exp=1/15/%h", dct_valid, dct_count, dct_buffer, pack(q));
    end
    step(0, 0, 0, 0, 1, 1);
  endtask

  task automatic test_random();
    bit fv, fl, te, rdy, ten;
    for (int c = 0; c < 400; c++) begin
      fv  = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      ten = ($urandom_range(0, 9) != 0);
      te  = (c == 330);
      step(fv, 2'($urandom_range(0, 3)), fl, te, rdy, ten);
      checks++; if (dct_valid !== m_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, dct_valid, m_valid); end
      if (m_valid) begin
        checks++; if (dct_count !== 4'(m_out.size()) || dct_buffer !== pack(m_out)) begin
          failures++; $display("FAIL rand_word cyc=%0d got=%0d/%h exp=%0d/%h", c, dct_count, dct_buffer, m_out.size(), pack(m_out));
        end
      end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rand_overflow cyc=%0d got=%b exp=%b", c, overflow, m_ovf); end
      checks++; if (test_ending !== (m_state == 1) || test_has_ended !== (m_state == 2)) begin
        failures++; $display("FAIL rand_fsm cyc=%0d got=%b/%b exp_state=%0d", c, test_ending, test_has_ended, m_state);
      end
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_full_word();
    test_flush();
    test_flush_same_cycle();
    test_backpressure();
    apply_reset();
    test_drain();
    apply_reset();
    test_reset_midword();
    apply_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
